// File: rtl/hs_pwm_pkg.sv
// Shared constants and types for the PWM burst bank: config field addresses,
// channel FSM states and the config legality rule.
package hs_pwm_pkg;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_HIGH   = 2'd1;
  localparam logic [1:0] ADDR_PULSES = 2'd2;
  localparam logic [1:0] ADDR_DELAY  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } pwm_state_e;

  // A period needs a rising and a falling edge inside it.
  function automatic logic cfg_legal(input logic [31:0] per, input logic [31:0] hi);
    return (per >= 32'd2) && (hi >= 32'd1) && (hi < per);
  endfunction

endpackage

// File: rtl/hs_pwm_bank_if.sv
// Config write bus from the UART register mapper into the PWM bank.
interface hs_pwm_bank_if #(
  parameter int CNT_W = 17,
  parameter int CH_W  = 3
);
  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_data;

  modport master (output cfg_wr, cfg_ch, cfg_addr, cfg_data);
  modport slave  (input  cfg_wr, cfg_ch, cfg_addr, cfg_data);
endinterface

// File: rtl/hs_pwm_channel.sv
// One PWM burst channel: config registers, IDLE/DELAY/RUN FSM, counters and
// registered status. Active copies of the config decouple writes from a running burst.
module hs_pwm_channel
  import hs_pwm_pkg::*;
#(
  parameter int   CNT_W    = 17,
  parameter int   PN_W     = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             wr_i,
  input  logic [1:0]       addr_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             pwm_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic             done_o
);

  logic [CNT_W-1:0] period_q, period_d, high_q, high_d, delay_q, delay_d;
  logic [PN_W-1:0]  pulses_q, pulses_d;
  logic             valid_q;

  pwm_state_e       state_q;
  logic [CNT_W-1:0] per_act_q, high_act_q, dly_q, phase_q;
  logic [PN_W-1:0]  pn_act_q, pcnt_q, pcnt_nxt;
  logic             out_q, busy_q, done_q;

  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    pulses_d = pulses_q;
    delay_d  = delay_q;
    if (wr_i) begin
      case (addr_i)
        ADDR_PERIOD: period_d = data_i;
        ADDR_HIGH:   high_d   = data_i;
        ADDR_PULSES: pulses_d = data_i[PN_W-1:0];
        default:     delay_d  = data_i;
      endcase
    end
  end

  // Legality is judged on the post-write values so it tracks the write by one cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      period_q <= '0;
      high_q   <= '0;
      pulses_q <= '0;
      delay_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      period_q <= period_d;
      high_q   <= high_d;
      pulses_q <= pulses_d;
      delay_q  <= delay_d;
      valid_q  <= cfg_legal(32'(period_d), 32'(high_d));
    end
  end

  assign pcnt_nxt = pcnt_q + 1'b1;

  // pwm_out lags the phase counter by one register, so a stop or burst end
  // forces IDLE_LVL on the same edge that the state leaves RUN.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      per_act_q  <= '0;
      high_act_q <= '0;
      pn_act_q   <= '0;
      dly_q      <= '0;
      phase_q    <= '0;
      pcnt_q     <= '0;
      out_q      <= IDLE_LVL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      out_q  <= IDLE_LVL;
      case (state_q)
        ST_IDLE: begin
          if (start_i && valid_q && !stop_i) begin
            per_act_q  <= period_q;
            high_act_q <= high_q;
            pn_act_q   <= pulses_q;
            dly_q      <= delay_q;
            pcnt_q     <= '0;
            phase_q    <= '0;
            busy_q     <= 1'b1;
            state_q    <= (delay_q != '0) ? ST_DELAY : ST_RUN;
          end
        end
        ST_DELAY: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (dly_q == CNT_W'(1)) begin
            state_q <= ST_RUN;
            phase_q <= '0;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            out_q <= (phase_q < high_act_q) ? ~IDLE_LVL : IDLE_LVL;
            if (phase_q == per_act_q - 1'b1) begin
              phase_q <= '0;
              pcnt_q  <= pcnt_nxt;
              if (pn_act_q != '0 && pcnt_nxt == pn_act_q) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else if (pn_act_q == '0 && valid_q) begin
                // Continuous mode: duty/period change only at the period boundary.
                per_act_q  <= period_q;
                high_act_q <= high_q;
              end
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_o   = out_q;
  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign done_o  = done_q;

endmodule

// File: rtl/hs_pwm_bank.sv
// N-channel PWM burst bank: decodes config writes to a one-hot channel strobe
// and gathers per-channel status into the output buses.
module hs_pwm_bank
  import hs_pwm_pkg::*;
#(
  parameter int   NUM_CH   = 7,
  parameter int   CNT_W    = 17,
  parameter int   PN_W     = 8,
  parameter int   CH_W     = 3,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  hs_pwm_bank_if.slave      cfg,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] pwm_busy,
  output logic [NUM_CH-1:0] pwm_valid,
  output logic [NUM_CH-1:0] burst_done
);

  logic [NUM_CH-1:0] wr_oh;

  // Out-of-range channel indices match no bit and are dropped.
  always_comb begin
    wr_oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_oh[i] = cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hs_pwm_channel #(
      .CNT_W    (CNT_W),
      .PN_W     (PN_W),
      .IDLE_LVL (IDLE_LVL)
    ) u_ch (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .wr_i    (wr_oh[g]),
      .addr_i  (cfg.cfg_addr),
      .data_i  (cfg.cfg_data),
      .start_i (start[g]),
      .stop_i  (stop[g]),
      .pwm_o   (pwm_out[g]),
      .busy_o  (pwm_busy[g]),
      .valid_o (pwm_valid[g]),
      .done_o  (burst_done[g])
    );
  end

endmodule

// File: tb/tb_hs_pwm_bank.sv
// Directed bench for hs_pwm_bank: bursts, delay, continuous update, invalid
// config, aborts, out-of-range writes and reset mid-burst.
module tb_hs_pwm_bank;

  localparam int NUM_CH = 7;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [NUM_CH-1:0] start   = '0;
  logic [NUM_CH-1:0] stop    = '0;
  logic [NUM_CH-1:0] pwm_out, pwm_busy, pwm_valid, burst_done;

  int n_chk  = 0;
  int n_fail = 0;

  hs_pwm_bank_if #(.CNT_W(17), .CH_W(3)) cfg_if ();

  hs_pwm_bank #(
    .NUM_CH(NUM_CH), .CNT_W(17), .PN_W(8), .CH_W(3), .IDLE_LVL(1'b0)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cfg        (cfg_if),
    .start      (start),
    .stop       (stop),
    .pwm_out    (pwm_out),
    .pwm_busy   (pwm_busy),
    .pwm_valid  (pwm_valid),
    .burst_done (burst_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input int ch, input int addr, input int data);
    cfg_if.cfg_wr   = 1'b1;
    cfg_if.cfg_ch   = 3'(ch);
    cfg_if.cfg_addr = 2'(addr);
    cfg_if.cfg_data = 17'(data);
    step(1);
    cfg_if.cfg_wr   = 1'b0;
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] m);
    start = m;
    step(1);
    start = '0;
  endtask

  initial begin
    cfg_if.cfg_wr   = 1'b0;
    cfg_if.cfg_ch   = '0;
    cfg_if.cfg_addr = '0;
    cfg_if.cfg_data = '0;

    step(2);
    sys_rst = 1'b0;
    chk("rst pwm_out", 32'(pwm_out), 32'h0);
    chk("rst busy", 32'(pwm_busy), 32'h0);
    chk("rst valid", 32'(pwm_valid), 32'h0);
    chk("rst done", 32'(burst_done), 32'h0);

    // Writes to channel 7 must not land anywhere.
    wr(7, 0, 10);
    wr(7, 1, 3);
    step(1);
    chk("ch7 write ignored", 32'(pwm_valid), 32'h0);

    // ch0 finite burst: 4 pulses of 3/10, no delay.
    wr(0, 0, 10);
    chk("ch0 valid after period only", 32'(pwm_valid[0]), 32'h0);
    wr(0, 1, 3);
    chk("ch0 valid", 32'(pwm_valid[0]), 32'h1);
    wr(0, 2, 4);
    wr(0, 3, 0);
    pulse_start(7'h01);
    chk("ch0 busy at t", 32'(pwm_busy[0]), 32'h1);
    chk("ch0 out at t", 32'(pwm_out[0]), 32'h0);
    for (int k = 1; k <= 41; k++) begin
      step(1);
      chk($sformatf("ch0 out k=%0d", k), 32'(pwm_out[0]), 32'(k <= 40 && ((k - 1) % 10) < 3));
      chk($sformatf("ch0 done k=%0d", k), 32'(burst_done[0]), 32'(k == 40));
      chk($sformatf("ch0 busy k=%0d", k), 32'(pwm_busy[0]), 32'(k < 40));
    end

    // ch2 single pulse after a 7-cycle delay.
    wr(2, 0, 5);
    wr(2, 1, 2);
    wr(2, 3, 7);
    wr(2, 2, 1);
    pulse_start(7'h04);
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) step(1);
      chk($sformatf("ch2 out k=%0d", k), 32'(pwm_out[2]), 32'(k == 8 || k == 9));
      chk($sformatf("ch2 done k=%0d", k), 32'(burst_done[2]), 32'(k == 12));
      chk($sformatf("ch2 busy k=%0d", k), 32'(pwm_busy[2]), 32'(k < 12));
    end

    // ch1 continuous 4/8, HIGH rewritten to 6 mid-period.
    wr(1, 0, 8);
    wr(1, 1, 4);
    pulse_start(7'h02);
    for (int k = 1; k <= 24; k++) begin
      step(1);
      chk($sformatf("ch1 out k=%0d", k), 32'(pwm_out[1]),
          32'((k <= 8) ? (((k - 1) % 8) < 4) : (((k - 1) % 8) < 6)));
      chk($sformatf("ch1 busy k=%0d", k), 32'(pwm_busy[1]), 32'h1);
      chk($sformatf("ch1 done k=%0d", k), 32'(burst_done[1]), 32'h0);
      if (k == 2) begin
        cfg_if.cfg_wr = 1'b1; cfg_if.cfg_ch = 3'd1; cfg_if.cfg_addr = 2'd1; cfg_if.cfg_data = 17'd6;
      end
      if (k == 3) cfg_if.cfg_wr = 1'b0;
    end
    stop = 7'h02;
    step(1);
    stop = '0;
    chk("ch1 stop out", 32'(pwm_out[1]), 32'h0);
    chk("ch1 stop busy", 32'(pwm_busy[1]), 32'h0);

    // ch4 illegal HIGH=PERIOD, then repaired.
    wr(4, 0, 6);
    wr(4, 1, 6);
    chk("ch4 invalid", 32'(pwm_valid[4]), 32'h0);
    pulse_start(7'h10);
    chk("ch4 invalid busy", 32'(pwm_busy[4]), 32'h0);
    step(1);
    chk("ch4 invalid out", 32'(pwm_out[4]), 32'h0);
    wr(4, 1, 5);
    chk("ch4 valid", 32'(pwm_valid[4]), 32'h1);
    pulse_start(7'h10);
    chk("ch4 busy", 32'(pwm_busy[4]), 32'h1);
    step(1);
    chk("ch4 out", 32'(pwm_out[4]), 32'h1);
    stop = 7'h10;
    step(1);
    stop = '0;
    chk("ch4 stop out", 32'(pwm_out[4]), 32'h0);

    // ch3 aborted in the middle of its high phase.
    wr(3, 0, 10);
    wr(3, 1, 6);
    wr(3, 2, 3);
    pulse_start(7'h08);
    step(3);
    chk("ch3 high before stop", 32'(pwm_out[3]), 32'h1);
    stop = 7'h08;
    step(1);
    stop = '0;
    chk("ch3 stop out", 32'(pwm_out[3]), 32'h0);
    chk("ch3 stop busy", 32'(pwm_busy[3]), 32'h0);
    chk("ch3 stop done", 32'(burst_done[3]), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk($sformatf("ch3 no done k=%0d", k), 32'(burst_done[3]), 32'h0);
    end

    // Start and stop together: stop wins.
    start = 7'h08;
    stop  = 7'h08;
    step(1);
    start = '0;
    stop  = '0;
    chk("ch3 start+stop busy", 32'(pwm_busy[3]), 32'h0);
    step(1);
    chk("ch3 start+stop out", 32'(pwm_out[3]), 32'h0);

    // All channels continuous 2/4, then reset mid-burst.
    for (int c = 0; c < NUM_CH; c++) begin
      wr(c, 0, 4);
      wr(c, 1, 2);
      wr(c, 2, 0);
      wr(c, 3, 0);
    end
    chk("all valid", 32'(pwm_valid), 32'h7f);
    pulse_start(7'h7f);
    chk("all busy", 32'(pwm_busy), 32'h7f);
    step(1);
    chk("all out high", 32'(pwm_out), 32'h7f);
    sys_rst = 1'b1;
    step(1);
    sys_rst = 1'b0;
    chk("midrst out", 32'(pwm_out), 32'h0);
    chk("midrst busy", 32'(pwm_busy), 32'h0);
    chk("midrst valid", 32'(pwm_valid), 32'h0);
    chk("midrst done", 32'(burst_done), 32'h0);
    pulse_start(7'h7f);
    chk("post-rst start ignored", 32'(pwm_busy), 32'h0);
    step(1);
    chk("post-rst out", 32'(pwm_out), 32'h0);
    chk("post-rst valid", 32'(pwm_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
